// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - request/grant/result bundle between the two requesters and alu_share_ctrl
interface alu_share_ctrl_if;
  logic       req0;
  logic       req1;
  logic [2:0] op0;
  logic [2:0] op1;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic       result_owner;
  logic [7:0] ops_done;

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  gnt0, gnt1, busy, result, result_valid, result_owner, ops_done
  );

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output gnt0, gnt1, busy, result, result_valid, result_owner, ops_done
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - two-requester arbiter/sequencer for the shared 4-bit ALU
// Define RR_ARB_EN for round-robin tie-break; otherwise requester 0 wins ties.
module alu_share_ctrl (
  input logic             clock,
  input logic             reset,
  alu_share_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic       owner;
  logic       win;
  logic       any_req;
  logic [2:0] op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [7:0] alu_out;
`ifdef RR_ARB_EN
  logic       last_owner;
`endif

  assign any_req = bus.req0 | bus.req1;

  always_comb begin
    win = bus.req1;
    if (bus.req0 && bus.req1) begin
`ifdef RR_ARB_EN
      win = ~last_owner;
`else
      win = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.gnt0         = 1'b0;
    bus.gnt1         = 1'b0;
    bus.busy         = 1'b1;
    bus.result_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (any_req) state_next = EXEC;
      end
      EXEC: begin
        bus.gnt0   = ~owner;
        bus.gnt1   = owner;
        state_next = DONE;
      end
      DONE: begin
        bus.result_valid = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_out = 8'h00;
    case (op_q)
      3'b001: alu_out = {3'b000, {1'b0, a_q} + {1'b0, b_q}};
      3'b010: alu_out = {~(a_q | b_q), ~(a_q & b_q)};
      3'b011: alu_out = ((a_q | b_q) != 4'h0) ? 8'hC0 : 8'h00;
      3'b100: alu_out = ($countones(a_q) == 2 && $countones(b_q) == 3) ? 8'h3F : 8'h00;
      3'b101: alu_out = {b_q, ~a_q};
      3'b110: alu_out = {a_q ^ b_q, ~(a_q ^ b_q)};
      default: alu_out = 8'h00;
    endcase
  end

  // Operands are captured only at the accepting edge so later input changes cannot disturb EXEC.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner            <= 1'b0;
      op_q             <= 3'b000;
      a_q              <= 4'h0;
      b_q              <= 4'h0;
      bus.result       <= 8'h00;
      bus.result_owner <= 1'b0;
      bus.ops_done     <= 8'h00;
`ifdef RR_ARB_EN
      last_owner       <= 1'b1;
`endif
    end else begin
      if (state == IDLE && any_req) begin
        owner <= win;
        op_q  <= win ? bus.op1 : bus.op0;
        a_q   <= win ? bus.a1  : bus.a0;
        b_q   <= win ? bus.b1  : bus.b0;
`ifdef RR_ARB_EN
        last_owner <= win;
`endif
      end
      if (state == EXEC) begin
        bus.result       <= alu_out;
        bus.result_owner <= owner;
        bus.ops_done     <= bus.ops_done + 8'h01;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - scoreboard bench for alu_share_ctrl with randomized requests
module tb_alu_share_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    bit       owner;
    bit [7:0] res;
    bit [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   m_ops = 0;
`ifdef RR_ARB_EN
  bit   m_last = 1'b1;
`endif

  alu_share_ctrl_if bus ();

  alu_share_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int popc(input int v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += (v >> i) & 1;
    return n;
  endfunction

  function automatic bit [7:0] alu_ref(input int op, input int a, input int b);
    int r;
    case (op)
      1: r = a + b;
      2: r = ((~(a | b) & 15) << 4) | (~(a & b) & 15);
      3: r = ((a | b) != 0) ? 'hC0 : 0;
      4: r = (popc(a) == 2 && popc(b) == 3) ? 'h3F : 0;
      5: r = (b << 4) | (~a & 15);
      6: r = ((a ^ b) << 4) | (~(a ^ b) & 15);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  function automatic bit pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef RR_ARB_EN
      return !m_last;
`else
      return 1'b0;
`endif
    end
    return r1;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 8) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input bit r0, input bit r1, input int o0, input int x0, input int y0,
                       input int o1, input int x1, input int y1);
    bit   w;
    exp_t e;
    wait_idle();
    bus.req0 = r0;  bus.req1 = r1;
    bus.op0 = 3'(o0); bus.a0 = 4'(x0); bus.b0 = 4'(y0);
    bus.op1 = 3'(o1); bus.a1 = 4'(x1); bus.b1 = 4'(y1);
    if (!(r0 || r1)) begin
      @(negedge clock);
      check("idle_no_req_busy", int'(bus.busy), 0);
      return;
    end
    w = pick(r0, r1);
`ifdef RR_ARB_EN
    m_last = w;
`endif
    m_ops = (m_ops + 1) % 256;
    e.owner = w;
    e.res   = w ? alu_ref(o1, x1, y1) : alu_ref(o0, x0, y0);
    e.cnt   = 8'(m_ops);
    sb.push_back(e);
    @(negedge clock);
    check("gnt0", int'(bus.gnt0), int'(w == 1'b0));
    check("gnt1", int'(bus.gnt1), int'(w == 1'b1));
    check("busy_exec", int'(bus.busy), 1);
    bus.req0 = 1'b0;  bus.req1 = 1'b0;
    bus.op0 = 3'($urandom); bus.a0 = 4'($urandom); bus.b0 = 4'($urandom);
    bus.op1 = 3'($urandom); bus.a1 = 4'($urandom); bus.b1 = 4'($urandom);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.gnt0 && bus.gnt1) check("gnt_overlap", 1, 0);
      if (bus.result_valid && (bus.gnt0 || bus.gnt1)) check("valid_with_gnt", 1, 0);
      if (bus.result_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", int'(bus.result), int'(e.res));
          check("result_owner", int'(bus.result_owner), int'(e.owner));
          check("ops_done", int'(bus.ops_done), int'(e.cnt));
        end
      end
    end
  end

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
    bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_gnt0", int'(bus.gnt0), 0);
    check("rst_gnt1", int'(bus.gnt1), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_valid", int'(bus.result_valid), 0);
    check("rst_owner", int'(bus.result_owner), 0);
    check("rst_ops", int'(bus.ops_done), 0);
    reset = 1'b0;

    issue(1, 0, 1, 5, 3, 0, 0, 0);
    issue(0, 1, 0, 0, 0, 6, 'hA, 6);
    issue(0, 1, 0, 0, 0, 2, 'hC, 'hA);
    issue(0, 1, 0, 0, 0, 5, 1, 9);
    issue(1, 0, 4, 3, 7, 0, 0, 0);
    issue(1, 0, 4, 3, 3, 0, 0, 0);
    issue(1, 0, 3, 0, 0, 0, 0, 0);
    issue(1, 0, 7, 'hF, 'hF, 0, 0, 0);
    repeat (6) issue(1, 1, 1, 2, 3, 6, 4, 5);
    repeat (3) issue(0, 0, 0, 0, 0, 0, 0, 0);

    repeat (150) issue(1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15),
                       $urandom_range(0, 15));

    wait_idle();
    bus.req0 = 1'b1; bus.op0 = 3'd1; bus.a0 = 4'hF; bus.b0 = 4'hF;
    @(negedge clock);
    check("abort_gnt0", int'(bus.gnt0), 1);
    reset = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clock);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_result", int'(bus.result), 0);
    check("abort_ops", int'(bus.ops_done), 0);
    check("abort_valid", int'(bus.result_valid), 0);
    reset = 1'b0;
    m_ops = 0;
`ifdef RR_ARB_EN
    m_last = 1'b1;
`endif
    @(negedge clock);
    check("abort_no_valid", int'(bus.result_valid), 0);
    check("abort_sb_empty", sb.size(), 0);

    for (int i = 0; i < 256; i++) begin
      bit r0 = 1'($urandom);
      bit r1 = r0 ? 1'($urandom) : 1'b1;
      issue(r0, r1, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    repeat (4) @(negedge clock);
    check("wrap_ops_done", int'(bus.ops_done), 0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
